// File: rtl/gate_sweep_checker.sv
// Sweep engine for the two-input basic-gates unit: drives all four {a,b} combinations,
// checks the seven gate outputs against the truth table and reports pass/fail diagnostics.
module gate_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic [6:0]       gate_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [6:0]       fail_mask,
    output logic [1:0]       fail_vec
);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SetW-1:0] SettleLast =
        SetW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W+2:0] ErrMax = {3'b000, {CNT_W{1'b1}}};

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [SetW-1:0]  set_cnt_q, set_cnt_d;
    logic [1:0]       ab_q, ab_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [6:0]       mask_q, mask_d;
    logic [1:0]       vec_q, vec_d;

    logic [6:0]       expected;
    logic [6:0]       mism;
    logic [2:0]       pop;
    logic [CNT_W+2:0] err_sum;

    // Truth table packed as {xny, xoy, nay, ay, noy, oy, ny}.
    always_comb begin
        expected = 7'h55;
        case (idx_q)
            2'd0:    expected = 7'h55;
            2'd1:    expected = 7'h33;
            2'd2:    expected = 7'h32;
            default: expected = 7'h4A;
        endcase
    end

    assign mism    = gate_in ^ expected;
    assign pop     = 3'($countones(mism));
    assign err_sum = {3'b000, err_q} + {{CNT_W{1'b0}}, pop};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        set_cnt_d = set_cnt_q;
        pass_d    = pass_q;
        err_d     = err_q;
        mask_d    = mask_q;
        vec_d     = vec_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = (SETTLE_CYCLES == 0) ? StCheck : StSettle;
                    idx_d     = 2'd0;
                    set_cnt_d = '0;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    mask_d    = '0;
                    vec_d     = 2'd0;
                end
            end
            StSettle: begin
                if (set_cnt_q == SettleLast) begin
                    state_d = StCheck;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            StCheck: begin
                err_d     = (err_sum > ErrMax) ? ErrMax[CNT_W-1:0] : err_sum[CNT_W-1:0];
                mask_d    = mask_q | mism;
                set_cnt_d = '0;
                // An all-zero mask means no earlier combination has failed this sweep.
                if ((mism != 7'h00) && (mask_q == 7'h00)) begin
                    vec_d = idx_q;
                end
                if (idx_q == 2'd3) begin
                    state_d = StDone;
                    pass_d  = (err_d == '0) && (mask_d == 7'h00);
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = (SETTLE_CYCLES == 0) ? StCheck : StSettle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StSettle) || (state_d == StCheck);
        done_d = (state_d == StDone);
        ab_d   = busy_d ? idx_d : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            set_cnt_q <= '0;
            ab_q      <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            mask_q    <= 7'h00;
            vec_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            set_cnt_q <= set_cnt_d;
            ab_q      <= ab_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
            vec_q     <= vec_d;
        end
    end

    assign a_out     = ab_q[1];
    assign b_out     = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;
    assign fail_vec  = vec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: golden, faulty and tied-off gate models,
// mid-sweep reset, ignored starts, back-to-back sweeps, saturation and zero settle time.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0, start3 = 1'b0, start0 = 1'b0;
    int   mode = 0;
    int   checks = 0;
    int   errors = 0;

    // Main DUT, S=2, CNT_W=8
    logic a, b, busy, done, pass;
    logic [6:0] gi, mask;
    logic [7:0] err;
    logic [1:0] vec;

    // Saturation DUT, S=2, CNT_W=3, gate_in tied low
    logic a3, b3, busy3, done3, pass3;
    logic [6:0] gi3, mask3;
    logic [2:0] err3;
    logic [1:0] vec3;

    // Zero-settle DUT, S=0, golden model
    logic a0, b0, busy0, done0, pass0;
    logic [6:0] gi0, mask0;
    logic [7:0] err0;
    logic [1:0] vec0;

    function automatic logic [6:0] gold(input logic ai, input logic bi);
        return {~(ai ^ bi), ai ^ bi, ~(ai & bi), ai & bi, ~(ai | bi), ai | bi, ~ai};
    endfunction

    always_comb begin
        gi = gold(a, b);
        if (mode == 1) gi[3] = 1'b0;
        if (mode == 2) gi = 7'h00;
        gi3 = 7'h00;
        gi0 = gold(a0, b0);
    end

    gate_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_out(a), .b_out(b), .gate_in(gi),
        .busy(busy), .done(done), .pass(pass), .err_count(err), .fail_mask(mask),
        .fail_vec(vec)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3), .gate_in(gi3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_mask(mask3),
        .fail_vec(vec3)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .gate_in(gi0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_mask(mask0),
        .fail_vec(vec0)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic dsel(input int sel);
        if (sel == 3) return done3;
        if (sel == 0) return done0;
        return done;
    endfunction

    // Counts edges until the selected done is seen; a timeout counts as a failure.
    task automatic wait_done(input int sel, input int limit, output int n);
        n = 0;
        forever begin
            cyc();
            n++;
            if (dsel(sel)) break;
            if (n >= limit) begin
                checks++;
                errors++;
                $display("FAIL wait_done sel=%0d: no done within %0d cycles", sel, limit);
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic check_results(input string tag, input logic ep, input logic [7:0] ee,
                                 input logic [6:0] em, input logic [1:0] ev);
        checks++;
        if (pass !== ep) begin
            errors++;
            $display("FAIL %s pass: got %b want %b", tag, pass, ep);
        end
        checks++;
        if (err !== ee) begin
            errors++;
            $display("FAIL %s err_count: got %0d want %0d", tag, err, ee);
        end
        checks++;
        if (mask !== em) begin
            errors++;
            $display("FAIL %s fail_mask: got %h want %h", tag, mask, em);
        end
        checks++;
        if (vec !== ev) begin
            errors++;
            $display("FAIL %s fail_vec: got %b want %b", tag, vec, ev);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++;
        if ({a, b, busy, done, pass, err, mask, vec} !== 22'd0) begin
            errors++;
            $display("FAIL reset outputs: got %h want 0",
                     {a, b, busy, done, pass, err, mask, vec});
        end
    endtask

    task automatic test_golden();
        int n;
        mode = 0;
        pulse_start();
        checks++;
        if ({busy, a, b} !== 3'b100) begin
            errors++;
            $display("FAIL golden after E0 {busy,a,b}: got %b want 100", {busy, a, b});
        end
        wait_done(1, 40, n);
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL golden latency: got %0d want 12", n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL golden busy at done: got %b want 0", busy);
        end
        check_results("golden", 1'b1, 8'd0, 7'h00, 2'b00);
        cyc();
        checks++;
        if ({done, pass} !== 2'b01) begin
            errors++;
            $display("FAIL golden done width/pass hold: got %b want 01", {done, pass});
        end
    endtask

    task automatic test_stuck_ay();
        int n;
        mode = 1;
        pulse_start();
        wait_done(1, 40, n);
        check_results("stuck_ay", 1'b0, 8'd1, 7'h08, 2'b11);
        cyc();
    endtask

    task automatic test_zero_and_saturate();
        int n;
        mode   = 2;
        start  = 1'b1;
        start3 = 1'b1;
        cyc();
        start  = 1'b0;
        start3 = 1'b0;
        wait_done(1, 40, n);
        check_results("zero", 1'b0, 8'd14, 7'h7F, 2'b00);
        checks++;
        if ({done3, pass3, err3, mask3, vec3} !== {1'b1, 1'b0, 3'd7, 7'h7F, 2'b00}) begin
            errors++;
            $display("FAIL saturate cnt3: got done=%b pass=%b err=%0d mask=%h vec=%b want 1 0 7 7f 00",
                     done3, pass3, err3, mask3, vec3);
        end
        cyc();
        mode = 0;
    endtask

    task automatic test_mid_reset();
        int n;
        int seen;
        mode = 0;
        pulse_start();
        cyc();
        cyc();
        cyc();
        checks++;
        if ({busy, a, b} !== 3'b101) begin
            errors++;
            $display("FAIL mid_reset index01: got %b want 101", {busy, a, b});
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({a, b, busy, done, pass, err, mask, vec} !== 22'd0) begin
            errors++;
            $display("FAIL mid_reset outputs: got %h want 0",
                     {a, b, busy, done, pass, err, mask, vec});
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset spurious activity: got %0d want 0", seen);
        end
        pulse_start();
        wait_done(1, 40, n);
        check_results("after_reset", 1'b1, 8'd0, 7'h00, 2'b00);
        cyc();
    endtask

    task automatic test_ignore_start();
        int n;
        int seen;
        pulse_start();
        cyc();
        cyc();
        pulse_start();
        wait_done(1, 40, n);
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL ignore latency after E0+3: got %0d want 9", n);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL ignore extra sweep activity: got %0d want 0", seen);
        end
        checks++;
        if (pass !== 1'b1) begin
            errors++;
            $display("FAIL ignore pass held: got %b want 1", pass);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start = 1'b1;
        wait_done(1, 40, n);
        for (int k = 0; k < 2; k++) begin
            wait_done(1, 40, n);
            checks++;
            if (n != 14) begin
                errors++;
                $display("FAIL back_to_back period %0d: got %0d want 14", k, n);
            end
            checks++;
            if (pass !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back pass %0d: got %b want 1", k, pass);
            end
        end
        start = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_zero_settle();
        logic [1:0] exp_ab;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_ab = 2'(k);
            checks++;
            if ({busy0, a0, b0} !== {1'b1, exp_ab}) begin
                errors++;
                $display("FAIL zero_settle step %0d {busy,a,b}: got %b want %b",
                         k, {busy0, a0, b0}, {1'b1, exp_ab});
            end
            cyc();
        end
        checks++;
        if ({done0, pass0, busy0, a0, b0} !== 5'b11000) begin
            errors++;
            $display("FAIL zero_settle done: got %b want 11000",
                     {done0, pass0, busy0, a0, b0});
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_golden();
        test_stuck_ay();
        test_zero_and_saturate();
        test_mid_reset();
        test_ignore_start();
        test_back_to_back();
        test_zero_settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking sweep engine that sits around the two-input basic-gates unit. Upstream, it drives the gate unit's `a`/`b` inputs through all four combinations. Downstream, it consumes the seven gate outputs, compares each against the expected truth table, and reports pass/fail, an error count and diagnostics. It is used for on-chip self-test and as a reusable bench component.

## Interface
- `SETTLE_CYCLES`, default 2: cycles `a`/`b` are held before the CHECK cycle; 0 is legal.
- `CNT_W`, default 8: width of `err_count`.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `a_out`  out  1  drives gate unit input `a`.
- `b_out`  out  1  drives gate unit input `b`.
- `gate_in`  in  7  gate outputs, bit order [0]=ny, [1]=oy, [2]=noy, [3]=ay, [4]=nay, [5]=xoy, [6]=xny.
- `busy`  out  1  high from start acceptance through the last CHECK.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  1 when the last completed sweep had zero mismatches; held until the next start.
- `err_count`  out  CNT_W  total mismatching bits in the sweep, saturating.
- `fail_mask`  out  7  OR of mismatching bit positions over the sweep.
- `fail_vec`  out  2  {a,b} of the first combination with any mismatch; 0 if none.

## Operation
- States:
  - IDLE: `start`=1 goes to SETTLE; clears `err_count`, `fail_mask`, `fail_vec`, `pass`; index=0.
  - SETTLE: counts SETTLE_CYCLES cycles, then goes to CHECK. When SETTLE_CYCLES=0, go directly to CHECK.
  - CHECK: one cycle; compare, then either go to SETTLE with index+1, or go to DONE when index=3.
  - DONE: one cycle, then IDLE.
- Combination order is index 0..3, with `a_out`=index[1] and `b_out`=index[0], i.e. 00, 01, 10, 11. `a_out`/`b_out` are registered and are 0 in IDLE and DONE.
- Expected `gate_in` by index: 00→7'h55, 01→7'h33, 10→7'h32, 11→7'h4A.
- On the clock edge that ends CHECK, with `mism` = `gate_in` XOR expected:
  - `err_count` += popcount(`mism`), saturating at 2^CNT_W−1;
  - `fail_mask` |= `mism`;
  - if `mism`≠0 and no earlier mismatch this sweep, `fail_vec` = index.
- On entry to DONE: `pass` = (final `err_count`==0 and `fail_mask`==0); `done`=1.
- `start` outside IDLE is ignored, not queued. `start` held high re-triggers in each IDLE cycle (back-to-back sweeps).
- Results stay stable from DONE until the next accepted start.

## Timing
- Reset (synchronous, any state): next cycle state=IDLE, and `a_out`, `b_out`, `busy`, `done`, `pass`, `err_count`, `fail_mask`, `fail_vec` are all 0. A reset mid-sweep discards partial results and produces no `done`.
- Let edge E0 be the edge that samples `start` in IDLE; S = SETTLE_CYCLES.
- After E0: `busy`=1 and `a_out`/`b_out`=00.
- Index k is driven for S+1 cycles. `gate_in` is sampled at edge E0+(k+1)(S+1), and the next combination appears on that same edge.
- `done`, updated `pass` and final results become visible after edge E0+4(S+1). `busy` falls on that same edge. `done` lasts exactly one cycle.
- Back-to-back period with `start` held high: 4(S+1)+2 cycles.
- `gate_in` is treated as combinational from `a_out`/`b_out` with delay under S+1 cycles. No input synchronisation is applied.
- Saturation: with CNT_W≥5, no saturation is reachable (maximum is 28 mismatches).

## Test plan
- Golden model on `gate_in`, S=2, pulse `start` → `done` rises 12 cycles after E0; `pass`=1, `err_count`=0, `fail_mask`=7'h00, `fail_vec`=0.
- `gate_in[3]` (ay) stuck at 0, otherwise golden → `err_count`=1, `fail_mask`=7'h08, `fail_vec`=2'b11, `pass`=0.
- `gate_in` tied to 7'h00 → `err_count`=14, `fail_mask`=7'h7F, `fail_vec`=2'b00, `pass`=0. Repeat with CNT_W=3 → `err_count`=7 (saturated).
- Assert `rst` for one cycle while index=01 is in SETTLE → next cycle all outputs 0 and `busy`=0, with no `done`. A following `start` gives a full correct sweep with `pass`=1.
- Pulse `start` again at E0+3 and during DONE → both ignored, only one `done`. Then hold `start` high → `done` pulses every 14 cycles (S=2) and `pass` stays 1.
- S=0 with golden model → `a_out`/`b_out` change every cycle (00, 01, 10, 11); `done` rises 4 cycles after E0; `pass`=1.
